// File: rtl/usr_shift_ctrl_if.sv
// Command/response handshake bundle between a transfer producer and usr_shift_ctrl.
// The controller sits on the slave side.
interface usr_shift_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_data;
   logic       cmd_dir;
   logic [3:0] cmd_len;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;

   modport master (
      output cmd_valid, cmd_data, cmd_dir, cmd_len, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_data, cmd_dir, cmd_len, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/usr_shift_ctrl.sv
// Sequencer for the 8-bit universal shift register: loads a command word, paces 1..8
// full-duplex shift steps, then returns the captured register contents.
module usr_shift_ctrl #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic              clk,
   input  logic              rst,
   usr_shift_ctrl_if.slave   hs,
   input  logic              abort,
   input  logic              sin,
   output logic              sout,
   output logic              bit_strobe,
   output logic              busy,
   output logic [1:0]        usr_mode,
   output logic [7:0]        usr_par_in,
   output logic              usr_ser_left,
   output logic              usr_ser_right,
   input  logic [7:0]        usr_q
);

   localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [PW-1:0] PACE_MAX = PW'(CLKS_PER_BIT - 1);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_LEFT  = 2'b01;
   localparam logic [1:0] MODE_RIGHT = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] pace_q, pace_nxt;
   logic [3:0]    bits_q, bits_nxt;
   logic [7:0]    data_q;
   logic          dir_q;
   logic          armed_q;
   logic          accept;
   logic          pace_end;

   // Lengths of 0 and 9..15 mean a full byte.
   function automatic logic [3:0] norm_len(input logic [3:0] len);
      return ((len == 4'd0) || (len > 4'd8)) ? 4'd8 : len;
   endfunction

   assign hs.cmd_ready = armed_q && (state == IDLE);
   assign accept       = hs.cmd_valid && hs.cmd_ready;
   assign pace_end     = (pace_q == PACE_MAX);

   assign busy         = (state != IDLE);
   assign hs.rsp_valid = (state == DONE);
   // The register holds in DONE, so its output is stable for the whole response.
   assign hs.rsp_data  = (state == DONE) ? usr_q : 8'h00;
   assign usr_par_in   = data_q;

   assign sout          = (state == SHIFT) ? (dir_q ? usr_q[0] : usr_q[7]) : 1'b0;
   assign usr_ser_right = busy && !dir_q && sin;
   assign usr_ser_left  = busy &&  dir_q && sin;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         pace_q  <= '0;
         bits_q  <= 4'd0;
         data_q  <= 8'h00;
         dir_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         pace_q  <= pace_nxt;
         bits_q  <= bits_nxt;
         armed_q <= 1'b1;
         if (accept) begin
            data_q <= hs.cmd_data;
            dir_q  <= hs.cmd_dir;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      pace_nxt   = pace_q;
      bits_nxt   = bits_q;
      usr_mode   = MODE_HOLD;
      bit_strobe = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = LOAD;
               bits_nxt  = norm_len(hs.cmd_len);
            end
         end
         LOAD: begin
            usr_mode  = MODE_LOAD;
            pace_nxt  = '0;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            if (pace_end) begin
               usr_mode   = dir_q ? MODE_RIGHT : MODE_LEFT;
               bit_strobe = 1'b1;
               pace_nxt   = '0;
               bits_nxt   = bits_q - 4'd1;
               if (bits_q == 4'd1) state_nxt = DONE;
            end else begin
               pace_nxt = pace_q + 1'b1;
            end
         end
         DONE: begin
            if (hs.rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Abort outranks both the last-step and the response transitions.
      if (abort && (state != IDLE)) state_nxt = IDLE;
   end

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Bench for usr_shift_ctrl: two instances (1 and 4 clocks per bit), each driving a
// behavioural universal shift register; results are checked against an arithmetic model.
module tb_usr_shift_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       cmd_valid [2];
   logic [7:0] cmd_data  [2];
   logic       cmd_dir   [2];
   logic [3:0] cmd_len   [2];
   logic       rsp_ready [2];
   logic       abort     [2];
   logic       sin       [2];
   logic       cmd_ready [2];
   logic       rsp_valid [2];
   logic [7:0] rsp_data  [2];
   logic       sout      [2];
   logic       bit_strobe[2];
   logic       busy      [2];
   logic [1:0] usr_mode  [2];
   logic [7:0] par_in    [2];
   logic       ser_l     [2];
   logic       ser_r     [2];
   logic [7:0] q         [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      usr_shift_ctrl_if bus ();
      logic [7:0] reg_q = 8'h00;

      assign bus.cmd_valid = cmd_valid[g];
      assign bus.cmd_data  = cmd_data[g];
      assign bus.cmd_dir   = cmd_dir[g];
      assign bus.cmd_len   = cmd_len[g];
      assign bus.rsp_ready = rsp_ready[g];
      assign cmd_ready[g]  = bus.cmd_ready;
      assign rsp_valid[g]  = bus.rsp_valid;
      assign rsp_data[g]   = bus.rsp_data;
      assign q[g]          = reg_q;

      usr_shift_ctrl #(.CLKS_PER_BIT(g == 0 ? 1 : 4)) dut (
         .clk          (clk),
         .rst          (rst),
         .hs           (bus),
         .abort        (abort[g]),
         .sin          (sin[g]),
         .sout         (sout[g]),
         .bit_strobe   (bit_strobe[g]),
         .busy         (busy[g]),
         .usr_mode     (usr_mode[g]),
         .usr_par_in   (par_in[g]),
         .usr_ser_left (ser_l[g]),
         .usr_ser_right(ser_r[g]),
         .usr_q        (reg_q)
      );

      // usr_8bit behaviour: 00 hold, 01 left (ser_right enters LSB), 10 right (ser_left enters MSB), 11 load.
      always @(posedge clk) begin
         case (usr_mode[g])
            2'b11:   reg_q <= par_in[g];
            2'b01:   reg_q <= {reg_q[6:0], ser_r[g]};
            2'b10:   reg_q <= {ser_l[g], reg_q[7:1]};
            default: reg_q <= reg_q;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_check(input int s);
      check("rst_cmd_ready",  32'(cmd_ready[s]),  32'(0));
      check("rst_busy",       32'(busy[s]),       32'(0));
      check("rst_rsp_valid",  32'(rsp_valid[s]),  32'(0));
      check("rst_rsp_data",   32'(rsp_data[s]),   32'(0));
      check("rst_usr_mode",   32'(usr_mode[s]),   32'(0));
      check("rst_par_in",     32'(par_in[s]),     32'(0));
      check("rst_ser",        32'({ser_l[s], ser_r[s]}), 32'(0));
      check("rst_bit_strobe", 32'(bit_strobe[s]), 32'(0));
      check("rst_sout",       32'(sout[s]),       32'(0));
   endtask

   task automatic wait_ready(input int s);
      int n = 0;
      while (cmd_ready[s] !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      check("cmd_ready_wait", 32'(cmd_ready[s]), 32'(1));
   endtask

   // One transfer. w holds the received bits as a len-bit word: sent MSB first for
   // left shifts, LSB first for right shifts. abort_at >= 0 aborts after that many strobes.
   task automatic xfer(input int s, input logic [7:0] data, input logic dir,
                       input logic [3:0] len_in, input logic [7:0] w,
                       input int stall, input int abort_at, output int hs_cyc);
      int cpb, len, mask, d, ww, strobes;
      logic [7:0] exp_q;
      logic exp_bit;
      cpb  = (s == 0) ? 1 : 4;
      len  = (len_in == 4'd0 || len_in > 4'd8) ? 8 : int'(len_in);
      mask = (1 << len) - 1;
      d    = int'(data);
      ww   = int'(w) & mask;
      exp_q = dir ? 8'((d >> len) | (ww << (8 - len))) : 8'((d << len) | ww);

      wait_ready(s);
      cmd_valid[s] = 1'b1;
      cmd_data[s]  = data;
      cmd_dir[s]   = dir;
      cmd_len[s]   = len_in;
      @(negedge clk);
      hs_cyc = cyc;
      cmd_valid[s] = 1'b0;
      cmd_data[s]  = 8'h00;
      check("load_mode",  32'(usr_mode[s]),  32'(3));
      check("load_par",   32'(par_in[s]),    32'(data));
      check("load_busy",  32'(busy[s]),      32'(1));
      check("load_ready", 32'(cmd_ready[s]), 32'(0));
      @(negedge clk);

      strobes = 0;
      for (int c = 0; c < len * cpb; c++) begin
         if (abort_at >= 0 && strobes == abort_at) begin
            abort[s] = 1'b1;
            @(negedge clk);
            abort[s] = 1'b0;
            check("abort_ready", 32'(cmd_ready[s]), 32'(1));
            check("abort_mode",  32'(usr_mode[s]),  32'(0));
            check("abort_busy",  32'(busy[s]),      32'(0));
            for (int k = 0; k < 4; k++) begin
               check("abort_no_rsp", 32'(rsp_valid[s]), 32'(0));
               @(negedge clk);
            end
            return;
         end
         sin[s]  = dir ? w[strobes] : w[len - 1 - strobes];
         exp_bit = dir ? data[strobes] : data[7 - strobes];
         #1;
         check("shift_strobe", 32'(bit_strobe[s]), 32'((c % cpb) == cpb - 1));
         check("shift_mode",   32'(usr_mode[s]),
               ((c % cpb) == cpb - 1) ? (dir ? 32'(2) : 32'(1)) : 32'(0));
         check("shift_sout",   32'(sout[s]), 32'(exp_bit));
         check("shift_ser",    32'({ser_l[s], ser_r[s]}),
               dir ? 32'({sin[s], 1'b0}) : 32'({1'b0, sin[s]}));
         check("shift_rspv",   32'(rsp_valid[s]), 32'(0));
         if ((c % cpb) == cpb - 1) strobes++;
         @(negedge clk);
      end

      check("done_latency", 32'(cyc - hs_cyc), 32'(len * cpb + 1));
      check("done_strobes", 32'(strobes),      32'(len));
      check("done_valid",   32'(rsp_valid[s]), 32'(1));
      check("done_data",    32'(rsp_data[s]),  32'(exp_q));
      check("done_mode",    32'(usr_mode[s]),  32'(0));
      check("done_sout",    32'(sout[s]),      32'(0));
      check("done_busy",    32'(busy[s]),      32'(1));
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         check("stall_valid", 32'(rsp_valid[s]), 32'(1));
         check("stall_data",  32'(rsp_data[s]),  32'(exp_q));
         check("stall_mode",  32'(usr_mode[s]),  32'(0));
         check("stall_ready", 32'(cmd_ready[s]), 32'(0));
      end
      rsp_ready[s] = 1'b1;
      @(negedge clk);
      rsp_ready[s] = 1'b0;
      check("post_valid", 32'(rsp_valid[s]), 32'(0));
      check("post_ready", 32'(cmd_ready[s]), 32'(1));
      check("post_busy",  32'(busy[s]),      32'(0));
   endtask

   initial begin
      int h1, h2;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cmd_valid[i] = 1'b0;
         cmd_data[i]  = 8'h00;
         cmd_dir[i]   = 1'b0;
         cmd_len[i]   = 4'd0;
         rsp_ready[i] = 1'b0;
         abort[i]     = 1'b0;
         sin[i]       = 1'b1;
      end
      #3;
      reset_check(0);
      reset_check(1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_before_edge", 32'(cmd_ready[0]), 32'(0));
      @(negedge clk);
      check("ready_after_rst0", 32'(cmd_ready[0]), 32'(1));
      check("ready_after_rst1", 32'(cmd_ready[1]), 32'(1));

      // Directed transfers from the functional description.
      xfer(0, 8'hA5, 1'b0, 4'd8, 8'h3C, 0, -1, h1);
      xfer(1, 8'h81, 1'b1, 4'd3, 8'h07, 0, -1, h1);
      xfer(0, 8'h6B, 1'b0, 4'd0,  8'hD2, 0, -1, h1);
      xfer(1, 8'h6B, 1'b1, 4'd12, 8'h2D, 0, -1, h1);

      // Abort has no effect while idle.
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      check("idle_abort_ready", 32'(cmd_ready[0]), 32'(1));
      check("idle_abort_busy",  32'(busy[0]),      32'(0));

      xfer(0, 8'hC3, 1'b0, 4'd8, 8'h99, 0, 3, h1);
      xfer(1, 8'h3C, 1'b1, 4'd8, 8'h55, 0, 3, h1);

      // Backpressure, then the next command at minimum spacing.
      xfer(0, 8'h5A, 1'b1, 4'd5, 8'h13, 20, -1, h1);
      xfer(0, 8'hE7, 1'b0, 4'd2, 8'h02, 0, -1, h2);
      check("spacing_after_stall", 32'(h2 - h1), 32'(5 + 3 + 20));
      xfer(0, 8'h1F, 1'b1, 4'd4, 8'h0A, 0, -1, h1);
      check("spacing_min", 32'(h1 - h2), 32'(2 + 3));

      // Asynchronous reset during LOAD.
      wait_ready(0);
      cmd_valid[0] = 1'b1;
      cmd_data[0]  = 8'hFF;
      cmd_dir[0]   = 1'b1;
      cmd_len[0]   = 4'd8;
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      sin[0] = 1'b1;
      check("pre_rst_load_mode", 32'(usr_mode[0]), 32'(3));
      #1 rst = 1'b1;
      #1 reset_check(0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Asynchronous reset during SHIFT on the slow instance.
      wait_ready(1);
      cmd_valid[1] = 1'b1;
      cmd_data[1]  = 8'hFF;
      cmd_dir[1]   = 1'b0;
      cmd_len[1]   = 4'd8;
      @(negedge clk);
      cmd_valid[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      sin[1] = 1'b1;
      #1;
      check("pre_rst_shift_busy", 32'(busy[1]), 32'(1));
      check("pre_rst_shift_sout", 32'(sout[1]), 32'(1));
      #1 rst = 1'b1;
      #1 reset_check(1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Randomized transfers on both pacing rates.
      for (int i = 0; i < 16; i++) begin
         xfer(int'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 8'($urandom), int'($urandom_range(0, 3)), -1, h1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
